// File: rtl/thread_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : thread_sched_pkg
// Description : Constants and types shared by the two-thread fetch scheduler
//               and the decode stage. Holds the datapath width, the thread
//               id type, the per-issue PC step, the thread start PCs and the
//               thread-select helper used by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package thread_sched_pkg;

    localparam int c_WORD_W = 16;
    localparam int c_PC_STEP = 2;
    localparam logic [c_WORD_W-1:0] c_T0_START = 16'h0000;
    localparam logic [c_WORD_W-1:0] c_T1_START = 16'h0001;

    typedef logic tid_t;

    localparam tid_t c_TID0 = 1'b0;
    localparam tid_t c_TID1 = 1'b1;

    // Picks the thread that issues next. live[i] is 1 while thread i has not
    // halted. Both live -> strict alternation away from the last issuer;
    // one live -> that one; none live -> thread 0 so fetch_addr stays defined.
    function automatic tid_t pick_tid(input logic [1:0] live, input tid_t last);
        tid_t sel;
        sel = c_TID0;
        if (live == 2'b11) begin
            sel = ~last;
        end else if (live[1] && !live[0]) begin
            sel = c_TID1;
        end
        return sel;
    endfunction

endpackage : thread_sched_pkg
`default_nettype wire

// File: rtl/thread_ctx.sv
`default_nettype none
// ============================================================================
// Module      : thread_ctx
// Description : Per-thread context: program counter, sticky halted flag and a
//               saturating issue counter.
// Ports       : clk, reset (async, active-low)
//               issue       - this thread issues on this edge
//               redirect    - redirect aimed at this thread
//               redirect_pc - PC to load on redirect
//               halt_set    - halt aimed at this thread
//               pc, halted, cnt - current context state
// Revision    : 1.0 - initial release
// ============================================================================
module thread_ctx
    import thread_sched_pkg::*;
#(
    parameter int                WORD_W   = c_WORD_W,
    parameter logic [WORD_W-1:0] START_PC = '0,
    parameter int                PC_STEP  = c_PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt_set,
    output logic [WORD_W-1:0] pc,
    output logic              halted,
    output logic [WORD_W-1:0] cnt
);

    logic [WORD_W-1:0] r_pc;
    logic              r_halted;
    logic [WORD_W-1:0] r_cnt;
    logic [WORD_W-1:0] w_pc_next;
    logic [WORD_W-1:0] w_cnt_next;

    // Priority: a halt arriving together with a redirect freezes the PC;
    // a redirect to a live thread beats the sequential increment; a redirect
    // to an already-halted thread is dropped.
    always_comb begin
        w_pc_next = r_pc;
        if (redirect && halt_set) begin
            w_pc_next = r_pc;
        end else if (redirect && !r_halted) begin
            w_pc_next = redirect_pc;
        end else if (issue) begin
            w_pc_next = r_pc + WORD_W'(PC_STEP);
        end
    end

    // Counter saturates at all-ones instead of wrapping.
    always_comb begin
        w_cnt_next = r_cnt;
        if (issue && (r_cnt != {WORD_W{1'b1}})) begin
            w_cnt_next = r_cnt + WORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= START_PC;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_pc  <= w_pc_next;
            r_cnt <= w_cnt_next;
            if (halt_set) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign pc     = r_pc;
    assign halted = r_halted;
    assign cnt    = r_cnt;

endmodule : thread_ctx
`default_nettype wire

// File: rtl/thread_sched.sv
`default_nettype none
// ============================================================================
// Module      : thread_sched
// Description : Two-thread barrel fetch scheduler. Alternates issue between
//               live threads, applies branch redirects and halts, and keeps
//               per-thread saturating issue counts.
// Ports       : clk, reset (async, active-low)
//               stall                                    - no issue this cycle
//               redirect_valid/redirect_tid/redirect_pc  - PC redirect
//               halt_valid/halt_tid                      - thread halt
//               fetch_valid/fetch_tid/fetch_addr         - issue this cycle
//               issued0/issued1                          - per-thread counts
//               halt                                     - both threads halted
// Revision    : 1.0 - initial release
// ============================================================================
module thread_sched
    import thread_sched_pkg::*;
#(
    parameter int                WORD_W   = c_WORD_W,
    parameter logic [WORD_W-1:0] T0_START = c_T0_START,
    parameter logic [WORD_W-1:0] T1_START = c_T1_START,
    parameter int                PC_STEP  = c_PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic              redirect_tid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt_valid,
    input  logic              halt_tid,
    output logic              fetch_valid,
    output logic              fetch_tid,
    output logic [WORD_W-1:0] fetch_addr,
    output logic [WORD_W-1:0] issued0,
    output logic [WORD_W-1:0] issued1,
    output logic              halt
);

    tid_t              r_last_tid;
    logic [WORD_W-1:0] w_pc  [2];
    logic [WORD_W-1:0] w_cnt [2];
    logic [1:0]        w_halted;
    logic [1:0]        w_live;
    tid_t              w_sel;
    logic              w_fetch_valid;

    assign w_live        = ~w_halted;
    assign w_sel         = pick_tid(w_live, r_last_tid);
    assign w_fetch_valid = !stall && (w_live != 2'b00);

    for (genvar i = 0; i < 2; i++) begin : g_ctx
        thread_ctx #(
            .WORD_W   (WORD_W),
            .START_PC ((i == 0) ? T0_START : T1_START),
            .PC_STEP  (PC_STEP)
        ) u_ctx (
            .clk         (clk),
            .reset       (reset),
            .issue       (w_fetch_valid && (w_sel == tid_t'(i))),
            .redirect    (redirect_valid && (redirect_tid == tid_t'(i))),
            .redirect_pc (redirect_pc),
            .halt_set    (halt_valid && (halt_tid == tid_t'(i))),
            .pc          (w_pc[i]),
            .halted      (w_halted[i]),
            .cnt         (w_cnt[i])
        );
    end

    // Reset to thread 1 so the first issue after reset goes to thread 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_tid <= c_TID1;
        end else if (w_fetch_valid) begin
            r_last_tid <= w_sel;
        end
    end

    assign fetch_valid = w_fetch_valid;
    assign fetch_tid   = w_sel;
    assign fetch_addr  = (w_sel == c_TID1) ? w_pc[1] : w_pc[0];
    assign issued0     = w_cnt[0];
    assign issued1     = w_cnt[1];
    assign halt        = &w_halted;

endmodule : thread_sched
`default_nettype wire

// File: tb/tb_thread_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_thread_sched
// Description : Self-checking bench for thread_sched. A behavioural model of
//               the two-thread scheduler is compared against the DUT on every
//               falling edge; directed sequences pin the model with literal
//               expectations, then randomized traffic runs against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thread_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        redirect_tid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_valid = 1'b0;
    logic        halt_tid = 1'b0;
    logic        fetch_valid;
    logic        fetch_tid;
    logic [15:0] fetch_addr;
    logic [15:0] issued0;
    logic [15:0] issued1;
    logic        halt;

    thread_sched dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .fetch_valid    (fetch_valid),
        .fetch_tid      (fetch_tid),
        .fetch_addr     (fetch_addr),
        .issued0        (issued0),
        .issued1        (issued1),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    int m_pc  [2];
    int m_cnt [2];
    bit m_halted [2];
    bit m_last;

    function automatic bit m_sel();
        if (!m_halted[0] && !m_halted[1]) return !m_last;
        if (!m_halted[0]) return 1'b0;
        if (!m_halted[1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_fv();
        return !stall && (!m_halted[0] || !m_halted[1]);
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit t;
        bit fv;
        int npc [2];
        int rt;
        if (!reset) begin
            m_pc[0] = 0;
            m_pc[1] = 1;
            m_halted[0] = 1'b0;
            m_halted[1] = 1'b0;
            m_last = 1'b1;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end else begin
            t = m_sel();
            fv = m_fv();
            npc = m_pc;
            if (fv) begin
                npc[t] = (m_pc[t] + 2) % 65536;
                if (m_cnt[t] < 65535) m_cnt[t] = m_cnt[t] + 1;
                m_last = t;
            end
            if (redirect_valid) begin
                rt = redirect_tid;
                if (halt_valid && (halt_tid == redirect_tid)) npc[rt] = m_pc[rt];
                else if (!m_halted[rt]) npc[rt] = redirect_pc;
            end
            if (halt_valid) m_halted[halt_tid] = 1'b1;
            m_pc = npc;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit et;
        bit ev;
        bit eh;
        logic [15:0] ea;
        if (chk_en) begin
            et = m_sel();
            ev = m_fv();
            eh = m_halted[0] && m_halted[1];
            ea = 16'(m_pc[et]);
            n_vec++;
            if (fetch_valid !== ev || fetch_tid !== et || fetch_addr !== ea ||
                issued0 !== 16'(m_cnt[0]) || issued1 !== 16'(m_cnt[1]) || halt !== eh) begin
                n_miss++;
                $display("FAIL cycle t=%0t got v/tid/addr/i0/i1/halt=%0d/%0d/%h/%h/%h/%0d expected %0d/%0d/%h/%h/%h/%0d",
                         $time, fetch_valid, fetch_tid, fetch_addr, issued0, issued1, halt,
                         ev, et, ea, 16'(m_cnt[0]), 16'(m_cnt[1]), eh);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic cyc_exp(input string n, input bit v, input bit t, input logic [15:0] a);
        peek();
        chk({n, ".valid"}, 32'(fetch_valid), 32'(v));
        chk({n, ".tid"},   32'(fetch_tid),   32'(t));
        chk({n, ".addr"},  32'(fetch_addr),  32'(a));
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        halt_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state
        peek();
        chk("rst.valid", 32'(fetch_valid), 32'd1);
        chk("rst.tid",   32'(fetch_tid),   32'd0);
        chk("rst.addr",  32'(fetch_addr),  32'h0000);
        chk("rst.halt",  32'(halt),        32'd0);
        chk("rst.i0",    32'(issued0),     32'd0);
        chk("rst.i1",    32'(issued1),     32'd0);
        tick();
        reset = 1'b1;

        // Plain alternation
        cyc_exp("alt0", 1'b1, 1'b0, 16'h0000);
        cyc_exp("alt1", 1'b1, 1'b1, 16'h0001);
        cyc_exp("alt2", 1'b1, 1'b0, 16'h0002);
        cyc_exp("alt3", 1'b1, 1'b1, 16'h0003);

        // Stall for two cycles after the first issue
        do_reset();
        cyc_exp("stl0", 1'b1, 1'b0, 16'h0000);
        stall = 1'b1;
        cyc_exp("stl1", 1'b0, 1'b1, 16'h0001);
        cyc_exp("stl2", 1'b0, 1'b1, 16'h0001);
        stall = 1'b0;
        peek();
        chk("stl.i0", 32'(issued0), 32'd1);
        chk("stl.i1", 32'(issued1), 32'd0);
        tick();
        cyc_exp("stl3", 1'b1, 1'b0, 16'h0002);

        // Redirect thread 0 in the cycle it issues
        do_reset();
        redirect_valid = 1'b1;
        redirect_tid = 1'b0;
        redirect_pc = 16'h0040;
        cyc_exp("rdr0", 1'b1, 1'b0, 16'h0000);
        redirect_valid = 1'b0;
        cyc_exp("rdr1", 1'b1, 1'b1, 16'h0001);
        cyc_exp("rdr2", 1'b1, 1'b0, 16'h0040);

        // Halt thread 1, then a redirect to it is ignored
        do_reset();
        halt_valid = 1'b1;
        halt_tid = 1'b1;
        cyc_exp("h1_0", 1'b1, 1'b0, 16'h0000);
        halt_valid = 1'b0;
        cyc_exp("h1_1", 1'b1, 1'b0, 16'h0002);
        redirect_valid = 1'b1;
        redirect_tid = 1'b1;
        redirect_pc = 16'h0080;
        cyc_exp("h1_2", 1'b1, 1'b0, 16'h0004);
        redirect_valid = 1'b0;
        cyc_exp("h1_3", 1'b1, 1'b0, 16'h0006);
        cyc_exp("h1_4", 1'b1, 1'b0, 16'h0008);

        // Halt thread 0 too: both halted
        halt_valid = 1'b1;
        halt_tid = 1'b0;
        cyc_exp("h0_0", 1'b1, 1'b0, 16'h000A);
        halt_valid = 1'b0;
        peek();
        chk("both.halt",  32'(halt),        32'd1);
        chk("both.valid", 32'(fetch_valid), 32'd0);
        chk("both.tid",   32'(fetch_tid),   32'd0);
        tick();
        reset = 1'b0;
        peek();
        chk("rp.halt", 32'(halt),       32'd0);
        chk("rp.addr", 32'(fetch_addr), 32'h0000);
        tick();
        reset = 1'b1;

        // PC wrap on thread 1
        redirect_valid = 1'b1;
        redirect_tid = 1'b1;
        redirect_pc = 16'hFFFF;
        cyc_exp("wrp0", 1'b1, 1'b0, 16'h0000);
        redirect_valid = 1'b0;
        cyc_exp("wrp1", 1'b1, 1'b1, 16'hFFFF);
        cyc_exp("wrp2", 1'b1, 1'b0, 16'h0002);
        cyc_exp("wrp3", 1'b1, 1'b1, 16'h0001);

        // Counter saturation on thread 0 (thread 1 halted so 0 issues every cycle)
        halt_valid = 1'b1;
        halt_tid = 1'b1;
        cyc_exp("sat0", 1'b1, 1'b0, 16'h0004);
        halt_valid = 1'b0;
        repeat (65540) tick();
        peek();
        chk("sat.i0a", 32'(issued0), 32'hFFFF);
        tick();
        peek();
        chk("sat.i0b",   32'(issued0),     32'hFFFF);
        chk("sat.valid", 32'(fetch_valid), 32'd1);
        tick();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (($urandom_range(0, 199) == 0) ||
                (m_halted[0] && m_halted[1] && $urandom_range(0, 9) == 0)) begin
                reset = 1'b0;
                stall = 1'b0;
                redirect_valid = 1'b0;
                halt_valid = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                stall = ($urandom_range(0, 3) == 0);
                redirect_valid = ($urandom_range(0, 6) == 0);
                redirect_tid = 1'($urandom_range(0, 1));
                redirect_pc = 16'($urandom);
                halt_valid = ($urandom_range(0, 59) == 0);
                halt_tid = 1'($urandom_range(0, 1));
                tick();
            end
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        halt_valid = 1'b0;
        peek();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_thread_sched
`default_nettype wire
